// File: rtl/ahb_arb2_pkg.sv
// Shared AHB-Lite types and encodings for the two-master arbiter slice.
package ahb_arb2_pkg;

  localparam logic [1:0] AHB_IDLE   = 2'b00;
  localparam logic [1:0] AHB_BUSY   = 2'b01;
  localparam logic [1:0] AHB_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_SEQ    = 2'b11;
  localparam logic       AHB_OKAY   = 1'b0;
  localparam logic       AHB_ERROR  = 1'b1;

  typedef struct packed {
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HREADY;
  } AhbC;

  typedef struct packed {
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
  } AhbR;

  // Which master owns the data phase currently at the slave.
  typedef enum logic [1:0] {
    DPH_NONE = 2'd0,
    DPH_M0   = 2'd1,
    DPH_M1   = 2'd2
  } dph_e;

  function automatic logic is_req(input logic [1:0] htrans);
    return (htrans == AHB_NONSEQ) || (htrans == AHB_SEQ);
  endfunction

endpackage

// File: rtl/ahb_hold_buf.sv
// One-entry HRDATA/HRESP holding register for a master whose response
// arrived while it was stalled waiting for its next address grant.
module ahb_hold_buf
  import ahb_arb2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_i,
  input  logic        clr_i,
  input  logic [31:0] rdata_i,
  input  logic        resp_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        resp_o
);

  logic        valid_q;
  logic [31:0] rdata_q;
  logic        resp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= AHB_OKAY;
    end else if (cap_i) begin
      valid_q <= 1'b1;
      rdata_q <= rdata_i;
      resp_q  <= resp_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign resp_o  = resp_q;

endmodule

// File: rtl/ahb_arb2.sv
// Two-master AHB-Lite arbiter: round-robin (or m0-fixed) address grant,
// burst lock on SEQ, data-phase ownership tracking and response hold buffers.
module ahb_arb2
  import ahb_arb2_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  AhbC  m0_c,
  output AhbR  m0_r,
  input  AhbC  m1_c,
  output AhbR  m1_r,
  output AhbC  s_c,
  input  AhbR  s_r
);

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             last_gnt_q, last_gnt_d;
  dph_e             dph_q, dph_d;
  logic [1:0]       hv, hr, cap, clr;
  logic [1:0][31:0] hd;
  AhbR              mr [2];
  logic             own;

  logic unused_ok;
  assign unused_ok = &{1'b0, m0_c.HSEL, m0_c.HREADY, m1_c.HSEL, m1_c.HREADY};

  assign req = {is_req(m1_c.HTRANS), is_req(m0_c.HTRANS)};

  always_comb begin
    gnt = '0;
    if (!rst && s_r.HREADY) begin
      // The last granted master keeps the bus for the rest of its burst.
      if (!last_gnt_q && m0_c.HTRANS == AHB_SEQ)      gnt[0] = 1'b1;
      else if (last_gnt_q && m1_c.HTRANS == AHB_SEQ)  gnt[1] = 1'b1;
      else if (req[0] && req[1]) begin
        if (FIXED_PRIO != 0 || last_gnt_q) gnt[0] = 1'b1;
        else                               gnt[1] = 1'b1;
      end
      else if (req[0]) gnt[0] = 1'b1;
      else if (req[1]) gnt[1] = 1'b1;
    end
  end

  always_comb begin
    s_c.HSEL   = gnt[0] | gnt[1];
    s_c.HADDR  = gnt[1] ? m1_c.HADDR  : m0_c.HADDR;
    s_c.HSIZE  = gnt[1] ? m1_c.HSIZE  : m0_c.HSIZE;
    s_c.HWRITE = gnt[1] ? m1_c.HWRITE : m0_c.HWRITE;
    s_c.HTRANS = gnt[0] ? m0_c.HTRANS : (gnt[1] ? m1_c.HTRANS : AHB_IDLE);
    s_c.HWDATA = (dph_q == DPH_M1) ? m1_c.HWDATA : m0_c.HWDATA;
    s_c.HREADY = s_r.HREADY;
  end

  always_comb begin
    dph_d      = dph_q;
    last_gnt_d = last_gnt_q;
    if (s_r.HREADY) dph_d = gnt[0] ? DPH_M0 : (gnt[1] ? DPH_M1 : DPH_NONE);
    if (gnt[0])      last_gnt_d = 1'b0;
    else if (gnt[1]) last_gnt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dph_q      <= DPH_NONE;
      last_gnt_q <= 1'b0;
    end else begin
      dph_q      <= dph_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // A completing response for a master that is stalled on its next request is
  // parked in the hold buffer and released in the cycle that master is granted.
  always_comb begin
    cap = '0;
    clr = '0;
    own = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      own   = (dph_q == ((i == 0) ? DPH_M0 : DPH_M1));
      mr[i] = '{HRDATA: '0, HREADY: 1'b1, HRESP: AHB_OKAY};
      if (!rst) begin
        if (hv[i]) begin
          mr[i].HRDATA = hd[i];
          mr[i].HRESP  = hr[i];
          mr[i].HREADY = gnt[i];
          clr[i]       = gnt[i];
        end else if (own) begin
          mr[i].HRDATA = s_r.HRDATA;
          mr[i].HRESP  = s_r.HRESP;
          if (!s_r.HREADY) begin
            mr[i].HREADY = 1'b0;
          end else if (req[i] && !gnt[i]) begin
            mr[i].HREADY = 1'b0;
            cap[i]       = 1'b1;
          end
        end else begin
          mr[i].HREADY = ~req[i] | gnt[i];
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_hold
    ahb_hold_buf u_hold (
      .clk     (clk),
      .rst     (rst),
      .cap_i   (cap[g]),
      .clr_i   (clr[g]),
      .rdata_i (s_r.HRDATA),
      .resp_i  (s_r.HRESP),
      .valid_o (hv[g]),
      .rdata_o (hd[g]),
      .resp_o  (hr[g])
    );
  end

  assign m0_r = mr[0];
  assign m1_r = mr[1];

endmodule

// File: doc/ahb_arb2.md
AHB_ARB2 -- requirements
Module: ahb_arb2

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration and 1 = m0 always wins.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port m0_c  input  AhbC  master 0 (data side) address/control/HWDATA; HSEL and HREADY fields ignored.
REQ-005 SHALL have port m0_r  output  AhbR  master 0 HRDATA/HREADY/HRESP.
REQ-006 SHALL have port m1_c  input  AhbC  master 1 (instruction fetch); HSEL and HREADY fields ignored.
REQ-007 SHALL have port m1_r  output  AhbR  master 1 response.
REQ-008 SHALL have port s_c  output  AhbC  shared AHB-Lite slave bus toward decoder/bootrom/other slaves.
REQ-009 SHALL have port s_r  input  AhbR  muxed slave response; s_r.HREADY is the bus HREADY.

Function
REQ-010 SHALL treat master i as requesting (req_i) when m{i}_c.HTRANS is NONSEQ or SEQ.
REQ-011 SHALL grant at most one master per cycle, combinationally, only when s_r.HREADY=1; with s_r.HREADY=0 there is no grant.
REQ-012 SHALL arbitrate round-robin on a registered last_gnt bit: with both requesting, the master other than last_gnt wins; with one requesting, that master wins. FIXED_PRIO=1 overrides so m0 wins ties.
REQ-013 SHALL keep the grant on the current master while its HTRANS=SEQ (burst lock), regardless of the other request.
REQ-014 SHALL drive s_c with the granted master's HADDR/HSIZE/HWRITE/HTRANS, and HSEL=1. With no grant: HTRANS=IDLE, HSEL=0, HADDR/HSIZE/HWRITE from m0.
REQ-015 SHALL drive s_c.HREADY = s_r.HREADY.
REQ-016 SHALL hold a registered data-phase owner dph in {NONE, M0, M1}; when s_r.HREADY=1, dph <= granted master (NONE if none). last_gnt updates on each grant.
REQ-017 SHALL drive s_c.HWDATA from the dph owner's HWDATA, and from m0 when dph=NONE.
REQ-018 SHALL, for master i with dph=i, s_r.HREADY=1 and either no new request or its request granted, drive m{i}_r = s_r with HREADY=1.
REQ-019 SHALL, for master i with dph=i, s_r.HREADY=1, req_i=1 and not granted, capture s_r.HRDATA/HRESP into hold buffer i (hold_v[i]<=1) and drive m{i}_r.HREADY=0.
REQ-020 SHALL, while hold_v[i]=1, drive m{i}_r.HRDATA/HRESP from buffer i. m{i}_r.HREADY=1 only in the cycle master i is granted; hold_v[i] then clears.
REQ-021 SHALL, for master i not in a data phase and without hold, drive m{i}_r.HREADY = ~req_i | granted_i, with HRESP=OKAY and HRDATA=0.
REQ-022 SHALL, when dph=i and s_r.HREADY=0, drive m{i}_r.HREADY=0 and pass through s_r.HRDATA/HRESP.
REQ-023 SHALL forward ERROR responses with unchanged timing. The two-cycle ERROR sequence is the slave's duty; the first ERROR cycle (HREADY=0) goes to the dph owner.
REQ-024 SHALL never present an address phase for a master whose previous data phase is unfinished at the slave; dph ownership guarantees this.
REQ-025 SHALL tolerate simultaneous first requests from both masters in the cycle after reset: m1 wins when last_gnt resets to M0.

Reset
REQ-026 SHALL, on rst=1 at posedge clk, set dph=NONE, last_gnt=M0 and hold_v=0, and clear hold data/resp to 0.
REQ-027 SHALL, while rst=1, drive s_c.HTRANS=IDLE, s_c.HSEL=0, and m0_r/m1_r with HREADY=1, HRESP=OKAY, HRDATA=0.
REQ-028 SHALL, when reset is asserted mid-transfer, abandon any in-flight data phase without retry or buffering.

Structure
REQ-029 SHALL take AhbC/AhbR and the AHB_IDLE/AHB_NONSEQ/AHB_SEQ/AHB_OKAY/AHB_ERROR constants from the shared AHB package; the dph encoding enum is added to that package.
REQ-030 SHALL instantiate sub-module ahb_hold_buf once per master (one-entry HRDATA/HRESP holding register with valid); all else is flat.

Verification
REQ-031 SHALL cover: m1 NONSEQ read of 0x0000_0100 alone, slave with 1 wait -> s_c.HSEL=1 next to that address; m1_r.HREADY=0 for one cycle, then 1 with the slave HRDATA.
REQ-032 SHALL cover: m0 and m1 NONSEQ in the first cycle after reset -> m1 granted first, m0 stalled (HREADY=0) and granted next; order M1, M0.
REQ-033 SHALL cover: m1 issuing back-to-back fetches while m0 requests, slave zero-wait returning 0xDEAD_BEEF for m1's first fetch -> hold_v[1]=1, m0 granted, m1 later sees HRDATA=0xDEAD_BEEF with HREADY=1.
REQ-034 SHALL cover: m0 4-beat SEQ burst with m1 requesting throughout -> all four beats on s_c consecutively before m1 is granted.
REQ-035 SHALL cover: m0 write with HWDATA=0x1234_5678 -> s_c.HWDATA=0x1234_5678 in the data phase while m1 owns the address phase.
REQ-036 SHALL cover: rst asserted during m0's wait-stated data phase -> next cycle dph=NONE, s_c.HTRANS=IDLE, and both HREADY outputs=1.
